// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter: round-robin between ALU (A) and load unit (B),
// one registered register-file write per cycle, plus a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  input  logic [AW-1:0]          a_addr,
  input  logic [DW-1:0]          a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [AW-1:0]          b_addr,
  input  logic [DW-1:0]          b_data,
  output logic                   b_ready,
  input  logic                   claim_valid,
  input  logic [AW-1:0]          claim_addr,
  output logic                   reg_write_en,
  output logic [AW-1:0]          reg_write_addr,
  output logic [DW-1:0]          reg_write_data,
  output logic [(2**AW)-1:0]     pend_mask,
  output logic                   last_grant
);

  localparam int unsigned NR = 2**AW;

  logic          grant_a;
  logic          grant_b;
  logic          xfer;
  logic [AW-1:0] xfer_addr;
  logic [DW-1:0] xfer_data;

  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [NR-1:0] pend_q,    pend_d;
  logic          last_q,    last_d;

  // Grant: a lone requester always wins; on a tie, the one not served last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      if (a_valid && (!b_valid || last_q)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign xfer      = grant_a | grant_b;
  assign xfer_addr = grant_b ? b_addr : a_addr;
  assign xfer_data = grant_b ? b_data : a_data;

  // Next state; a claim is applied after the transfer clear so it wins on collision.
  always_comb begin
    wr_en_d   = xfer;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pend_d    = pend_q;
    last_d    = last_q;
    if (xfer) begin
      wr_addr_d         = xfer_addr;
      wr_data_d         = xfer_data;
      pend_d[xfer_addr] = 1'b0;
      last_d            = grant_b;
    end
    if (claim_valid) begin
      pend_d[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pend_q    <= '0;
      last_q    <= 1'b1;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pend_q    <= pend_d;
      last_q    <= last_d;
    end
  end

  assign a_ready        = grant_a;
  assign b_ready        = grant_b;
  assign reg_write_en   = wr_en_q;
  assign reg_write_addr = wr_addr_q;
  assign reg_write_data = wr_data_q;
  assign pend_mask      = pend_q;
  assign last_grant     = last_q;

endmodule
